cordic_iter_engine: RTL and testbench

- Iterative CORDIC micro-rotation engine: one shift-add micro-rotation per clock.
- Supports circular, linear and hyperbolic coordinate systems, in rotation or vectoring mode.
- Generates its shift-index sequence internally, including the hyperbolic repeat steps, and pairs it with the matching elementary-angle constant.
- Sits between the operand front-end (start valid/ready) and the result consumer (result valid/ready).

---
 rtl/cordic_iter_engine_if.sv | 29 ++
 rtl/cordic_iter_engine.sv | 171 +++++++++++++++++
 tb/tb_cordic_iter_engine.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_engine_if.sv
// Operand-request and result-delivery channels of the CORDIC iteration engine.
// Signal suffixes are from the engine's point of view.
interface cordic_iter_engine_if #(
    parameter int W = 16
);
    logic                start_valid_i;
    logic                start_ready_o;
    logic [1:0]          coordinate_system_i;
    logic                mode_i;
    logic signed [W-1:0] x_in_i;
    logic signed [W-1:0] y_in_i;
    logic signed [W-1:0] z_in_i;
    logic                res_valid_o;
    logic                res_ready_i;
    logic signed [W-1:0] x_out_o;
    logic signed [W-1:0] y_out_o;
    logic signed [W-1:0] z_out_o;
    logic                busy_o;

    modport master (
        output start_valid_i, coordinate_system_i, mode_i, x_in_i, y_in_i, z_in_i, res_ready_i,
        input  start_ready_o, res_valid_o, x_out_o, y_out_o, z_out_o, busy_o
    );

    modport slave (
        input  start_valid_i, coordinate_system_i, mode_i, x_in_i, y_in_i, z_in_i, res_ready_i,
        output start_ready_o, res_valid_o, x_out_o, y_out_o, z_out_o, busy_o
    );
endinterface

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one shift-add micro-rotation per clock in circular,
// linear or hyperbolic coordinates, rotation or vectoring mode.
module cordic_iter_engine #(
    parameter int W    = 16,
    parameter int ITER = 16
) (
    input  logic                clk,
    input  logic                rst,
    cordic_iter_engine_if.slave bus
);
    localparam int          WI   = W + 2;
    localparam int unsigned F    = W - 3;
    localparam int unsigned SH_L = (F > 16) ? F - 16 : 0;
    localparam int unsigned SH_R = (F < 16) ? 16 - F : 0;
    localparam logic [5:0]  LAST = 6'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [WI-1:0] MAXV = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [WI-1:0] MINV = {3'b111, {(W-1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic signed [WI-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [5:0]           k_q, k_d, cnt_q, cnt_d;
    logic                 rep_q, rep_d;
    logic [1:0]           cs_q, cs_d;
    logic                 mode_q, mode_d;

    logic signed [WI-1:0] xs, ys, e;
    logic                 d_pos, rep_k;

    // Circular/hyperbolic angles in 2^-16 rad; beyond the table they equal 2^-k.
    function automatic logic [31:0] rom16(input logic [5:0] k, input logic hyp);
        logic [31:0] c;
        int unsigned kk;
        kk = 32'(k);
        if (kk <= 16)      c = 32'd1 << (16 - kk);
        else if (kk == 17) c = 32'd1;
        else               c = '0;
        if (hyp) begin
            case (k)
                6'd0: c = '0;
                6'd1: c = 32'd35999;
                6'd2: c = 32'd16739;
                6'd3: c = 32'd8235;
                6'd4: c = 32'd4101;
                6'd5: c = 32'd2049;
                default: ;
            endcase
        end else begin
            case (k)
                6'd0: c = 32'd51472;
                6'd1: c = 32'd30386;
                6'd2: c = 32'd16055;
                6'd3: c = 32'd8150;
                6'd4: c = 32'd4091;
                6'd5: c = 32'd2047;
                default: ;
            endcase
        end
        return c;
    endfunction

    function automatic logic signed [WI-1:0] elem(input logic [5:0] k, input logic [1:0] cs);
        logic [31:0] t;
        int unsigned kk;
        kk = 32'(k);
        if (cs == 2'b01) begin
            if (kk <= F)          t = 32'd1 << (F - kk);
            else if (kk == F + 1) t = 32'd1;
            else                  t = '0;
        end else begin
            t = rom16(k, cs[1]) << SH_L;
            t = (t + ((32'd1 << SH_R) >> 1)) >> SH_R;
        end
        return WI'(t);
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [WI-1:0] v);
        if (v > MAXV)      return {1'b0, {(W-1){1'b1}}};
        else if (v < MINV) return {1'b1, {(W-1){1'b0}}};
        else               return v[W-1:0];
    endfunction

    always_comb begin
        xs    = x_q >>> k_q;
        ys    = y_q >>> k_q;
        e     = elem(k_q, cs_q);
        d_pos = mode_q ? y_q[WI-1] : ~z_q[WI-1];
        rep_k = (k_q == 6'd4) || (k_q == 6'd13) || (k_q == 6'd40);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        cs_d    = cs_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_valid_i) begin
                    x_d     = {{2{bus.x_in_i[W-1]}}, bus.x_in_i};
                    y_d     = {{2{bus.y_in_i[W-1]}}, bus.y_in_i};
                    z_d     = {{2{bus.z_in_i[W-1]}}, bus.z_in_i};
                    cs_d    = bus.coordinate_system_i;
                    mode_d  = bus.mode_i;
                    cnt_d   = '0;
                    rep_d   = 1'b0;
                    k_d     = bus.coordinate_system_i[1] ? 6'd1 : 6'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cs_q == 2'b00)   x_d = d_pos ? x_q - ys : x_q + ys;
                else if (cs_q[1])    x_d = d_pos ? x_q + ys : x_q - ys;
                y_d   = d_pos ? y_q + xs : y_q - xs;
                z_d   = d_pos ? z_q - e : z_q + e;
                cnt_d = cnt_q + 6'd1;
                // Hyperbolic k = 4, 13, 40 run twice; rep_q marks the second pass.
                if (cs_q[1] && rep_k && !rep_q) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    k_d   = k_q + 6'd1;
                end
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            rep_q   <= 1'b0;
            cs_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            cs_q    <= cs_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.start_ready_o = (state_q == S_IDLE) && !rst;
    assign bus.res_valid_o   = (state_q == S_DONE) && !rst;
    assign bus.busy_o        = ((state_q == S_RUN) || (state_q == S_DONE)) && !rst;
    assign bus.x_out_o       = sat(x_q);
    assign bus.y_out_o       = sat(y_q);
    assign bus.z_out_o       = sat(z_q);
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: directed vectors, queued expectations,
// independent result monitor plus handshake, latency and reset checks.
module tb_cordic_iter_engine;
    localparam int W    = 16;
    localparam int ITER = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_iter_engine_if #(.W(W)) bus ();

    cordic_iter_engine #(.W(W), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string name;
        int    xe, xt, ye, yt, ze, zt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   kseq[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req, input int tol);
        n_checks++;
        if (act < req - tol || act > req + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (+/-%0d)", name, act, req, tol);
        end
    endtask

    // Monitor: compare every completed result handshake against the queue head.
    exp_t mexp;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.res_valid_o && bus.res_ready_i) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got x=%0d y=%0d z=%0d, required no result",
                             bus.x_out_o, bus.y_out_o, bus.z_out_o);
                end else begin
                    mexp = sbq.pop_front();
                    check({mexp.name, ".x"}, int'(bus.x_out_o), mexp.xe, mexp.xt);
                    check({mexp.name, ".y"}, int'(bus.y_out_o), mexp.ye, mexp.yt);
                    check({mexp.name, ".z"}, int'(bus.z_out_o), mexp.ze, mexp.zt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int x, input int y, input int z, input logic [1:0] cs,
                         input logic md, output int acc_cyc);
        bit ok;
        tick();
        bus.x_in_i              = W'(x);
        bus.y_in_i              = W'(y);
        bus.z_in_i              = W'(z);
        bus.coordinate_system_i = cs;
        bus.mode_i              = md;
        bus.start_valid_i       = 1'b1;
        ok      = 1'b0;
        acc_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.start_ready_o) begin
                acc_cyc = cyc;
                ok      = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.start_valid_i       = 1'b0;
        bus.coordinate_system_i = 2'b11;
        bus.mode_i              = ~md;
        if (!ok) check("issue.start_ready_timeout", 0, 1, 0);
    endtask

    task automatic wait_valid(output int vc);
        bit ok;
        ok = 1'b0;
        vc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.res_valid_o) begin
                vc = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_valid.timeout", 0, 1, 0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.start_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle.timeout", 0, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required completion within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc, vc, sx, sy, sz;
        bit  same, seen;

        bus.start_valid_i       = 1'b0;
        bus.coordinate_system_i = 2'b00;
        bus.mode_i              = 1'b0;
        bus.x_in_i              = '0;
        bus.y_in_i              = '0;
        bus.z_in_i              = '0;
        bus.res_ready_i         = 1'b1;

        repeat (3) @(negedge clk);
        check("reset.start_ready", int'(bus.start_ready_o), 0, 0);
        check("reset.res_valid", int'(bus.res_valid_o), 0, 0);
        check("reset.busy", int'(bus.busy_o), 0, 0);
        check("reset.outputs_zero",
              int'(bus.x_out_o == 0 && bus.y_out_o == 0 && bus.z_out_o == 0), 1, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset.start_ready_after", int'(bus.start_ready_o), 1, 0);

        // Circular rotation by pi/4 with latency measurement.
        sbq.push_back('{"circ_rot", 5793, 8, 5793, 8, 0, 8});
        issue(4975, 0, 6434, 2'b00, 1'b0, acc);
        wait_valid(vc);
        check("circ_rot.latency", vc - acc, ITER + 1, 0);
        wait_idle();

        sbq.push_back('{"circ_vec", 19079, 16, 0, 8, 6434, 8});
        issue(8192, 8192, 0, 2'b00, 1'b1, acc);
        wait_valid(vc);
        wait_idle();

        sbq.push_back('{"lin_rot", 8192, 0, 4096, 4, 0, 8});
        issue(8192, 0, 4096, 2'b01, 1'b0, acc);
        wait_valid(vc);
        wait_idle();

        // Hyperbolic rotation with shift-index probe over all steps.
        sbq.push_back('{"hyp_rot", 9237, 16, 4269, 16, 0, 16});
        issue(9892, 0, 4096, 2'b10, 1'b0, acc);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("hyp.k[%0d]", i), int'(dut.k_q), kseq[i], 0);
        end
        wait_valid(vc);
        wait_idle();

        // Result stall with spurious start requests during RUN and DONE.
        tick();
        bus.res_ready_i = 1'b0;
        sbq.push_back('{"stall", 5793, 8, 5793, 8, 0, 8});
        issue(4975, 0, 6434, 2'b00, 1'b0, acc);
        bus.x_in_i = 16'sd1000;
        bus.coordinate_system_i = 2'b01;
        bus.start_valid_i = 1'b1;
        tick();
        bus.start_valid_i = 1'b0;
        wait_valid(vc);
        sx = int'(bus.x_out_o);
        sy = int'(bus.y_out_o);
        sz = int'(bus.z_out_o);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.start_valid_i = (i % 2 == 0);
            @(negedge clk);
            same = (int'(bus.x_out_o) == sx) && (int'(bus.y_out_o) == sy) && (int'(bus.z_out_o) == sz);
            check($sformatf("stall.res_valid[%0d]", i), int'(bus.res_valid_o), 1, 0);
            check($sformatf("stall.start_ready[%0d]", i), int'(bus.start_ready_o), 0, 0);
            check($sformatf("stall.outputs_stable[%0d]", i), int'(same), 1, 0);
        end
        tick();
        bus.start_valid_i = 1'b0;
        bus.res_ready_i   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall.res_valid_after", int'(bus.res_valid_o), 0, 0);
        check("stall.start_ready_after", int'(bus.start_ready_o), 1, 0);
        repeat (3) @(negedge clk);
        check("stall.no_second_op", int'(bus.busy_o), 0, 0);

        // Reset during RUN step 5: the operation must vanish without a result.
        issue(4975, 0, 6434, 2'b00, 1'b0, acc);
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst.start_ready_in_rst", int'(bus.start_ready_o), 0, 0);
        check("midrst.busy_in_rst", int'(bus.busy_o), 0, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst.start_ready_after", int'(bus.start_ready_o), 1, 0);
        check("midrst.outputs_zero",
              int'(bus.x_out_o == 0 && bus.y_out_o == 0 && bus.z_out_o == 0), 1, 0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.res_valid_o) seen = 1'b1;
        end
        check("midrst.no_res_valid", int'(seen), 0, 0);

        sbq.push_back('{"post_rst_rot", 5793, 8, 5793, 8, 0, 8});
        issue(4975, 0, 6434, 2'b00, 1'b0, acc);
        wait_valid(vc);
        wait_idle();

        sbq.push_back('{"saturate", 32767, 0, 0, 40, 6434, 8});
        issue(32767, 32767, 0, 2'b00, 1'b1, acc);
        wait_valid(vc);
        wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard.drained", sbq.size(), 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
